ysyx_23060286_lsu: RTL and testbench

Load/store unit; the consumer of the decoder's memory-control word (mem_op = {size_code[2:0], write}).
- Accepts one memory request at a time from the execute stage.
- Checks alignment, generates byte strobes and lane-shifted store data, and runs a valid/ready transaction on the data-memory bus.
- Returns sign- or zero-extended load data to writeback as a one-cycle result pulse.

---
 rtl/ysyx_23060286_pkg.sv | 24 ++
 rtl/ysyx_23060286_lsu_align.sv | 58 +++++
 rtl/ysyx_23060286_lsu.sv | 154 +++++++++++++++
 tb/tb_ysyx_23060286_lsu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060286_pkg.sv
// Shared memory-op constants and LSU state encoding.
// The decoder and the LSU both use these, so mem_op encodings live in one place.
package ysyx_23060286_pkg;

  // Size codes carried in mem_op[3:1]
  localparam logic [2:0] MEM_W  = 3'b000;
  localparam logic [2:0] MEM_BU = 3'b001;
  localparam logic [2:0] MEM_HS = 3'b010;
  localparam logic [2:0] MEM_HU = 3'b011;
  localparam logic [2:0] MEM_BS = 3'b100;

  // mem_op bit positions
  localparam int MEM_OP_WE    = 0;
  localparam int MEM_OP_SZ_LO = 1;
  localparam int MEM_OP_SZ_HI = 3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_23060286_lsu_align.sv
// Combinational byte-lane logic: store strobes/shift, load extract/extend,
// and alignment / illegal-size detection. No state, so a cached path can reuse it.
module ysyx_23060286_lsu_align
  import ysyx_23060286_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          addr_lo_i,
  input  logic [2:0]          size_i,
  input  logic                we_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   ldata_o,
  output logic                err_o
);

  logic [DATA_W-1:0] lane;

  assign wdata_o = wdata_i << {addr_lo_i, 3'b000};
  assign lane    = rdata_i >> {addr_lo_i, 3'b000};

  // Decode size into strobes, extended load data and the fault flag
  always_comb begin
    wstrb_o = '0;
    ldata_o = lane;
    err_o   = 1'b0;
    case (size_i)
      MEM_W: begin
        wstrb_o = 4'b1111;
        err_o   = |addr_lo_i;
      end
      MEM_BU: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        ldata_o = {24'b0, lane[7:0]};
      end
      MEM_BS: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        ldata_o = {{24{lane[7]}}, lane[7:0]};
      end
      MEM_HU: begin
        wstrb_o = 4'b0011 << addr_lo_i;
        ldata_o = {16'b0, lane[15:0]};
        err_o   = addr_lo_i[0];
      end
      MEM_HS: begin
        wstrb_o = 4'b0011 << addr_lo_i;
        ldata_o = {{16{lane[15]}}, lane[15:0]};
        err_o   = addr_lo_i[0];
      end
      default: err_o = 1'b1;
    endcase
    // Reads never assert strobes
    if (!we_i) wstrb_o = '0;
  end

endmodule

// File: rtl/ysyx_23060286_lsu.sv
// Load/store unit: one request at a time, IDLE -> REQ -> WAIT -> DONE.
// Faulting requests (misaligned / illegal size) skip the bus and go straight to DONE.
// Optional watchdog on REQ/WAIT enabled by defining LSU_TIMEOUT_EN.
module ysyx_23060286_lsu
  import ysyx_23060286_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [3:0]          req_mem_op,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  lsu_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                err_q, err_d;

  // Align unit sees the incoming request while idle (to fault-check and
  // pre-shift it) and the latched request otherwise (to extract load data).
  logic                idle;
  logic [1:0]          al_addr;
  logic [3:0]          al_op;
  logic [DATA_W/8-1:0] al_wstrb;
  logic [DATA_W-1:0]   al_wdata, al_ldata;
  logic                al_err;

  assign idle    = (state_q == LSU_IDLE);
  assign al_addr = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_op   = idle ? req_mem_op    : op_q;

  ysyx_23060286_lsu_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo_i (al_addr),
    .size_i    (al_op[MEM_OP_SZ_HI:MEM_OP_SZ_LO]),
    .we_i      (al_op[MEM_OP_WE]),
    .wdata_i   (req_wdata),
    .rdata_i   (mem_rdata),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata),
    .ldata_o   (al_ldata),
    .err_o     (al_err)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo;
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYCLES;
`endif

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        op_d    = req_mem_op;
        wdata_d = al_wdata;
        wstrb_d = al_wstrb;
        res_d   = '0;
        err_d   = al_err;
        state_d = al_err ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ:  if (mem_req_ready) state_d = LSU_WAIT;
      LSU_WAIT: if (mem_resp_valid) begin
        err_d   = mem_resp_err;
        res_d   = (mem_resp_err || op_q[MEM_OP_WE]) ? '0 : al_ldata;
        state_d = LSU_DONE;
      end
      default:  state_d = LSU_IDLE;
    endcase
`ifdef LSU_TIMEOUT_EN
    // Watchdog fires only when the bus made no progress this cycle
    if ((state_q == LSU_REQ || state_q == LSU_WAIT) && state_d == state_q && tmo) begin
      err_d   = 1'b1;
      res_d   = '0;
      state_d = LSU_DONE;
    end
    cnt_d = cnt_q;
    if (state_d == LSU_REQ && state_q != LSU_REQ) cnt_d = '0;
    else if (state_q == LSU_REQ || state_q == LSU_WAIT) cnt_d = cnt_q + 1'b1;
`endif
  end

  // State and captured request/response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign req_ready     = idle;
  assign mem_req_valid = (state_q == LSU_REQ);
  assign mem_we        = op_q[MEM_OP_WE];
  assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign resp_valid    = (state_q == LSU_DONE);
  assign resp_rdata    = resp_valid ? res_q : '0;
  assign resp_err      = resp_valid & err_q;

endmodule

// File: tb/tb_ysyx_23060286_lsu.sv
// Directed bench for ysyx_23060286_lsu; bus slave behaviour is scripted per transaction.
module tb_ysyx_23060286_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_mem_op = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp_err = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errs = 0;
  int checks = 0;

  // Observations from the last scripted transaction
  int          o_pulses, o_lat;
  bit          o_saw, o_stable;
  logic [31:0] o_addr, o_wd, o_rdata;
  logic [3:0]  o_strb;
  logic        o_we, o_err;

  always #5 clk = ~clk;

  ysyx_23060286_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mem_op(req_mem_op),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // Issue one request; bus holds ready low for rdy_dly REQ cycles and
  // answers rsp_dly cycles later than the earliest legal response.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] op,
                        input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rd, input logic rerr);
    int n = 0, w = 0;
    bit hs_pend = 0, waiting = 0, resp_sent = 0;
    o_pulses = 0; o_lat = -1; o_saw = 0; o_stable = 1;
    o_addr = '0; o_wd = '0; o_strb = '0; o_we = 0; o_rdata = '0; o_err = 0;
    @(negedge clk);
    req_valid = 1; req_addr = a; req_wdata = wd; req_mem_op = op;
    @(negedge clk);
    req_valid = 0;
    for (int k = 1; k < 400; k++) begin
      if (hs_pend) begin waiting = 1; hs_pend = 0; end
      if (resp_sent) begin mem_resp_valid = 0; mem_resp_err = 0; resp_sent = 0; end
      if (resp_valid) begin
        o_pulses++;
        if (o_pulses == 1) begin o_lat = k; o_rdata = resp_rdata; o_err = resp_err; end
      end
      if (mem_req_valid) begin
        if (n == 0) begin
          o_saw = 1; o_addr = mem_addr; o_wd = mem_wdata; o_strb = mem_wstrb; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_wdata !== o_wd ||
                     mem_wstrb !== o_strb || mem_we !== o_we) o_stable = 0;
        n++;
        mem_req_ready = (n > rdy_dly);
        hs_pend = mem_req_ready;
      end else mem_req_ready = 0;
      if (waiting) begin
        w++;
        if (w > rsp_dly) begin
          mem_resp_valid = 1; mem_rdata = rd; mem_resp_err = rerr;
          resp_sent = 1; waiting = 0;
        end
      end
      if (o_pulses > 0 && k >= o_lat + 3) break;
      @(negedge clk);
    end
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errs++; $display("FAIL reset_mem_fields got=%h_%h exp=0", mem_addr, mem_wdata); end
    checks++; if ({mem_wstrb, mem_we, resp_err, resp_rdata} !== 38'h0) begin errs++; $display("FAIL reset_misc got=%h %b %b %h exp=0", mem_wstrb, mem_we, resp_err, resp_rdata); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_store;
    do_txn(32'h80000004, 32'hDEADBEEF, 4'b0001, 0, 0, 32'h0, 1'b0);
    checks++; if (o_strb !== 4'b1111) begin errs++; $display("FAIL sw_wstrb got=%b exp=1111", o_strb); end
    checks++; if (o_wd !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wdata got=%h exp=deadbeef", o_wd); end
    checks++; if (o_addr !== 32'h80000004 || o_we !== 1'b1) begin errs++; $display("FAIL sw_addr_we got=%h/%b exp=80000004/1", o_addr, o_we); end
    checks++; if (o_lat !== 3) begin errs++; $display("FAIL sw_latency got=%0d exp=3", o_lat); end
    checks++; if (o_err !== 1'b0 || o_rdata !== 32'h0) begin errs++; $display("FAIL sw_resp got=%b/%h exp=0/0", o_err, o_rdata); end
    checks++; if (o_pulses !== 1) begin errs++; $display("FAIL sw_pulses got=%0d exp=1", o_pulses); end
    do_txn(32'h80000003, 32'h000000A5, 4'b0011, 0, 0, 32'h0, 1'b0);
    checks++; if (o_addr !== 32'h80000000) begin errs++; $display("FAIL sb_addr got=%h exp=80000000", o_addr); end
    checks++; if (o_strb !== 4'b1000) begin errs++; $display("FAIL sb_wstrb got=%b exp=1000", o_strb); end
    checks++; if (o_wd !== 32'hA5000000) begin errs++; $display("FAIL sb_wdata got=%h exp=a5000000", o_wd); end
    do_txn(32'h80000002, 32'h00001234, 4'b0111, 0, 0, 32'h0, 1'b0);
    checks++; if (o_strb !== 4'b1100 || o_wd !== 32'h12340000) begin errs++; $display("FAIL sh_lane got=%b/%h exp=1100/12340000", o_strb, o_wd); end
  endtask

  task automatic test_load;
    logic [31:0] a_tab [5] = '{32'h80000001, 32'h80000002, 32'h80000002, 32'h80000002, 32'h80000000};
    logic [3:0]  o_tab [5] = '{4'b1000, 4'b1000, 4'b0110, 4'b0100, 4'b0000};
    logic [31:0] e_tab [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01};
    for (int i = 0; i < 5; i++) begin
      do_txn(a_tab[i], 32'hFFFFFFFF, o_tab[i], 0, 0, 32'h80FF7F01, 1'b0);
      checks++; if (o_rdata !== e_tab[i] || o_err !== 1'b0) begin errs++; $display("FAIL load_%0d got=%h/%b exp=%h/0", i, o_rdata, o_err, e_tab[i]); end
      checks++; if (o_strb !== 4'b0000 || o_we !== 1'b0 || o_addr !== 32'h80000000) begin errs++; $display("FAIL load_bus_%0d got=%b/%b/%h exp=0000/0/80000000", i, o_strb, o_we, o_addr); end
    end
  endtask

  task automatic test_fault;
    do_txn(32'h80000001, 32'h0, 4'b0100, 0, 0, 32'h12345678, 1'b0);
    checks++; if (o_saw !== 1'b0) begin errs++; $display("FAIL mis_half_bus got=%b exp=0", o_saw); end
    checks++; if (o_lat !== 1) begin errs++; $display("FAIL mis_half_latency got=%0d exp=1", o_lat); end
    checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin errs++; $display("FAIL mis_half_resp got=%b/%h exp=1/0", o_err, o_rdata); end
    do_txn(32'h80000002, 32'h0, 4'b0001, 0, 0, 32'h0, 1'b0);
    checks++; if (o_saw !== 1'b0 || o_err !== 1'b1) begin errs++; $display("FAIL mis_word got=%b/%b exp=0/1", o_saw, o_err); end
    do_txn(32'h80000000, 32'h0, 4'b1010, 0, 0, 32'h0, 1'b0);
    checks++; if (o_saw !== 1'b0 || o_err !== 1'b1 || o_lat !== 1) begin errs++; $display("FAIL illegal_size got=%b/%b/%0d exp=0/1/1", o_saw, o_err, o_lat); end
  endtask

  task automatic test_backpressure;
    do_txn(32'h80000008, 32'hCAFEF00D, 4'b0001, 5, 4, 32'h0, 1'b0);
    checks++; if (o_stable !== 1'b1) begin errs++; $display("FAIL bp_stable got=%b exp=1", o_stable); end
    checks++; if (o_pulses !== 1) begin errs++; $display("FAIL bp_pulses got=%0d exp=1", o_pulses); end
    checks++; if (o_lat !== 12) begin errs++; $display("FAIL bp_latency got=%0d exp=12", o_lat); end
    do_txn(32'h80000000, 32'h0, 4'b0000, 2, 1, 32'h55AA55AA, 1'b1);
    checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin errs++; $display("FAIL bus_err got=%b/%h exp=1/0", o_err, o_rdata); end
    checks++; if (o_pulses !== 1) begin errs++; $display("FAIL bus_err_pulses got=%0d exp=1", o_pulses); end
  endtask

  task automatic test_reset_mid;
    int cnt = 0;
    // Reset while stalled in REQ: bus valid must drop without a clock edge
    @(negedge clk);
    req_valid = 1; req_addr = 32'h80000010; req_mem_op = 4'b0001; req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 0;
    checks++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL rst_req_pre got=%b exp=1", mem_req_valid); end
    #2 rst_n = 0; #1;
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_async got=%b/%b exp=0/1", mem_req_valid, req_ready); end
    checks++; if (mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_req_fields got=%h/%b/%h exp=0", mem_addr, mem_wstrb, mem_wdata); end
    @(negedge clk); rst_n = 1;
    // Reset while in WAIT, then a stray late response
    @(negedge clk);
    req_valid = 1; req_addr = 32'h80000020; req_mem_op = 4'b0000;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin errs++; $display("FAIL rst_wait_pre got=%b/%b exp=0/0", mem_req_valid, req_ready); end
    #2 rst_n = 0; #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_addr !== 32'h0) begin errs++; $display("FAIL rst_wait_async got=%b/%b/%h exp=1/0/0", req_ready, resp_valid, mem_addr); end
    @(negedge clk);
    rst_n = 1; mem_resp_valid = 1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    mem_resp_valid = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt !== 0 || req_ready !== 1'b1) begin errs++; $display("FAIL stray_resp got=%0d/%b exp=0/1", cnt, req_ready); end
  endtask

  task automatic test_back_to_back;
    do_txn(32'h80000000, 32'h0, 4'b0010, 0, 0, 32'h000000F0, 1'b0);
    checks++; if (o_rdata !== 32'h000000F0 || o_lat !== 3) begin errs++; $display("FAIL b2b_0 got=%h/%0d exp=000000f0/3", o_rdata, o_lat); end
    do_txn(32'h80000003, 32'h0, 4'b1000, 0, 0, 32'h9100_0000, 1'b0);
    checks++; if (o_rdata !== 32'hFFFFFF91 || o_lat !== 3) begin errs++; $display("FAIL b2b_1 got=%h/%0d exp=ffffff91/3", o_rdata, o_lat); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    do_txn(32'h80000000, 32'h0, 4'b0000, 0, 100000, 32'h0, 1'b0);
    checks++; if (o_err !== 1'b1 || o_pulses !== 1) begin errs++; $display("FAIL timeout_resp got=%b/%0d exp=1/1", o_err, o_pulses); end
    checks++; if (o_lat !== 256) begin errs++; $display("FAIL timeout_latency got=%0d exp=256", o_lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
